// File: rtl/serial_adder_if.sv
// Serial adder request/result bus.
// The optional sub signal exists only when SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             c_out;

  // Requester side: issues operands, observes status and result
  modport master (
    output start, a, b, c_in,
`ifdef SERIAL_ADDER_SUB_EN
    output sub,
`endif
    input  busy, done, sum, c_out
  );

  // Adder side
  modport slave (
    input  start, a, b, c_in,
`ifdef SERIAL_ADDER_SUB_EN
    input  sub,
`endif
    output busy, done, sum, c_out
  );
endinterface

// File: rtl/serial_adder_fsm.sv
// Bit-serial adder: one full-adder step per SHIFT cycle, LSB first.
// Optional feature macro: SERIAL_ADDER_SUB_EN (adds bus.sub for a-b).
module serial_adder_fsm #(
  parameter int unsigned WIDTH = 8
) (
  input logic           clk,
  input logic           rst_n,
  serial_adder_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_out_q, c_out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] load_b;
  logic             load_c;
  logic             s_bit;
  logic             c_nxt;

  // Operand/carry values captured when a start is accepted
`ifdef SERIAL_ADDER_SUB_EN
  assign load_b = bus.sub ? ~bus.b : bus.b;
  assign load_c = bus.sub | bus.c_in;
`else
  assign load_b = bus.b;
  assign load_c = bus.c_in;
`endif

  // Full-adder step on the operand LSBs and the carry flop
  always_comb begin
    s_bit = a_q[0] ^ b_q[0] ^ carry_q;
    c_nxt = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    c_out_d = c_out_q;

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = load_b;
          carry_d = load_c;
          cnt_d   = '0;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = c_nxt;
        acc_d   = {s_bit, acc_q[WIDTH-1:1]};
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          // Last step: publish the word including the bit formed this cycle
          state_d = DONE;
          sum_d   = {s_bit, acc_q[WIDTH-1:1]};
          c_out_d = c_nxt;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == SHIFT);
    done_d = (state_d == DONE);
  end

  // State, datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.sum   = sum_q;
  assign bus.c_out = c_out_q;
endmodule

// File: tb/tb_serial_adder_fsm.sv
// Directed bench for serial_adder_fsm at WIDTH=8.
module tb_serial_adder_fsm;
  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  serial_adder_if #(.WIDTH(8)) bus ();

  serial_adder_fsm #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

`ifdef SERIAL_ADDER_SUB_EN
  logic sub_sel;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one operation (called at a negedge); optionally pokes start with
  // a=b=0x11 at negedge 'poke' while busy. Observes 14 negedges after accept.
  task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                        input int poke, output logic [7:0] s, output logic co,
                        output logic [7:0] s_mid, output int lat,
                        output int nbusy, output int ndone);
    bus.a     = av;
    bus.b     = bv;
    bus.c_in  = cv;
`ifdef SERIAL_ADDER_SUB_EN
    bus.sub   = sub_sel;
`endif
    bus.start = 1'b1;
    @(posedge clk);
    lat = 0; nbusy = 0; ndone = 0; s = '0; co = 1'b0; s_mid = '0;
    for (int n = 1; n <= 14; n++) begin
      @(negedge clk);
      if (n == 1) begin
        bus.start = 1'b0;
        s_mid = bus.sum;
      end
      if (poke != 0 && n == poke) begin
        bus.start = 1'b1;
        bus.a     = 8'h11;
        bus.b     = 8'h11;
      end
      if (poke != 0 && n == poke + 1) bus.start = 1'b0;
      if (bus.busy) nbusy++;
      if (bus.done) begin
        ndone++;
        if (lat == 0) begin
          lat = n;
          s   = bus.sum;
          co  = bus.c_out;
        end
      end
    end
  endtask

  task automatic test_reset();
    logic [7:0] s, s_mid;
    logic co;
    int lat, nb, nd;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", bus.done); end
    n_vec++; if (bus.sum !== 8'h00) begin n_err++; $display("FAIL reset_sum: got %h want 00", bus.sum); end
    n_vec++; if (bus.c_out !== 1'b0) begin n_err++; $display("FAIL reset_c_out: got %b want 0", bus.c_out); end
    // Release and present start for the very first edge afterwards
    rst_n = 1'b1;
    run_op(8'h00, 8'h00, 1'b0, 0, s, co, s_mid, lat, nb, nd);
    n_vec++; if (lat !== 9) begin n_err++; $display("FAIL zero_latency: got %0d want 9", lat); end
    n_vec++; if (s !== 8'h00) begin n_err++; $display("FAIL zero_sum: got %h want 00", s); end
    n_vec++; if (co !== 1'b0) begin n_err++; $display("FAIL zero_c_out: got %b want 0", co); end
    n_vec++; if (nb !== 8) begin n_err++; $display("FAIL zero_busy_cycles: got %0d want 8", nb); end
    n_vec++; if (nd !== 1) begin n_err++; $display("FAIL zero_done_pulses: got %0d want 1", nd); end
  endtask

  task automatic test_add_vectors();
    logic [7:0] va [3] = '{8'hFF, 8'hA5, 8'h3C};
    logic [7:0] vb [3] = '{8'h01, 8'h5A, 8'h42};
    logic       vc [3] = '{1'b0, 1'b1, 1'b0};
    logic [7:0] es [3] = '{8'h00, 8'h00, 8'h7E};
    logic       ec [3] = '{1'b1, 1'b1, 1'b0};
    logic [7:0] s, s_mid;
    logic co;
    int lat, nb, nd;
    for (int i = 0; i < 3; i++) begin
      run_op(va[i], vb[i], vc[i], 0, s, co, s_mid, lat, nb, nd);
      n_vec++; if (lat !== 9) begin n_err++; $display("FAIL add%0d_latency: got %0d want 9", i, lat); end
      n_vec++; if (s !== es[i]) begin n_err++; $display("FAIL add%0d_sum: got %h want %h", i, s, es[i]); end
      n_vec++; if (co !== ec[i]) begin n_err++; $display("FAIL add%0d_c_out: got %b want %b", i, co, ec[i]); end
    end
  endtask

  task automatic test_busy_ignore();
    logic [7:0] s, s_mid;
    logic co;
    int lat, nb, nd;
    run_op(8'h0F, 8'h01, 1'b0, 3, s, co, s_mid, lat, nb, nd);
    n_vec++; if (s_mid !== 8'h7E) begin n_err++; $display("FAIL hold_prev_sum: got %h want 7e", s_mid); end
    n_vec++; if (s !== 8'h10) begin n_err++; $display("FAIL ignore_sum: got %h want 10", s); end
    n_vec++; if (co !== 1'b0) begin n_err++; $display("FAIL ignore_c_out: got %b want 0", co); end
    n_vec++; if (nb !== 8) begin n_err++; $display("FAIL ignore_busy_cycles: got %0d want 8", nb); end
    n_vec++; if (nd !== 1) begin n_err++; $display("FAIL ignore_done_pulses: got %0d want 1", nd); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] s, s_mid;
    logic co;
    int lat, nb, nd, ndone;
    bus.a = 8'h0F; bus.b = 8'h01; bus.c_in = 1'b0; bus.start = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      if (n == 1) bus.start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b want 0", bus.busy); end
    n_vec++; if (bus.sum !== 8'h00) begin n_err++; $display("FAIL midrst_sum: got %h want 00", bus.sum); end
    n_vec++; if (bus.c_out !== 1'b0) begin n_err++; $display("FAIL midrst_c_out: got %b want 0", bus.c_out); end
    n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL midrst_done: got %b want 0", bus.done); end
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    n_vec++; if (ndone !== 0) begin n_err++; $display("FAIL midrst_no_done: got %0d want 0", ndone); end
    run_op(8'h3C, 8'h42, 1'b0, 0, s, co, s_mid, lat, nb, nd);
    n_vec++; if (s !== 8'h7E) begin n_err++; $display("FAIL midrst_after_sum: got %h want 7e", s); end
    n_vec++; if (lat !== 9) begin n_err++; $display("FAIL midrst_after_latency: got %0d want 9", lat); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] va [3] = '{8'h01, 8'h10, 8'h80};
    logic [7:0] vb [3] = '{8'h01, 8'h20, 8'h80};
    logic [7:0] es [3] = '{8'h02, 8'h30, 8'h00};
    logic       ec [3] = '{1'b0, 1'b0, 1'b1};
    int idx, last;
    idx = 0; last = 0;
    bus.a = va[0]; bus.b = vb[0]; bus.c_in = 1'b0; bus.start = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (idx < 3 && bus.done) begin
        n_vec++; if (bus.sum !== es[idx]) begin n_err++; $display("FAIL b2b%0d_sum: got %h want %h", idx, bus.sum, es[idx]); end
        n_vec++; if (bus.c_out !== ec[idx]) begin n_err++; $display("FAIL b2b%0d_c_out: got %b want %b", idx, bus.c_out, ec[idx]); end
        n_vec++; if (n - last !== 9) begin n_err++; $display("FAIL b2b%0d_spacing: got %0d want 9", idx, n - last); end
        last = n;
        idx++;
        if (idx < 3) begin
          bus.a = va[idx];
          bus.b = vb[idx];
        end else begin
          bus.start = 1'b0;
        end
      end
    end
    bus.start = 1'b0;
    n_vec++; if (idx !== 3) begin n_err++; $display("FAIL b2b_count: got %0d want 3", idx); end
  endtask

`ifdef SERIAL_ADDER_SUB_EN
  task automatic test_sub();
    logic [7:0] s, s_mid;
    logic co;
    int lat, nb, nd;
    sub_sel = 1'b1;
    run_op(8'h10, 8'h01, 1'b0, 0, s, co, s_mid, lat, nb, nd);
    n_vec++; if (s !== 8'h0F) begin n_err++; $display("FAIL sub0_sum: got %h want 0f", s); end
    n_vec++; if (co !== 1'b1) begin n_err++; $display("FAIL sub0_c_out: got %b want 1", co); end
    run_op(8'h01, 8'h02, 1'b0, 0, s, co, s_mid, lat, nb, nd);
    n_vec++; if (s !== 8'hFF) begin n_err++; $display("FAIL sub1_sum: got %h want ff", s); end
    n_vec++; if (co !== 1'b0) begin n_err++; $display("FAIL sub1_c_out: got %b want 0", co); end
    sub_sel = 1'b0;
  endtask
`endif

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.c_in = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    sub_sel = 1'b0;
    bus.sub = 1'b0;
`endif
    test_reset();
    test_add_vectors();
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
`ifdef SERIAL_ADDER_SUB_EN
    test_sub();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
